// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use, branch-flush and memory-wait hazard controller
module hazard_stall_ctrl #(
    parameter int STALL_CNT_W = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   in_clk,
    input  logic                   in_rst_n,
    input  logic                   in_idex_memread,
    input  logic [4:0]             in_idex_rd,
    input  logic [4:0]             in_ifid_rs1,
    input  logic [4:0]             in_ifid_rs2,
    input  logic                   in_ifid_rs1_used,
    input  logic                   in_ifid_rs2_used,
    input  logic                   in_branch_taken,
    input  logic                   in_dmem_req,
    input  logic                   in_dmem_ready,
    output logic                   out_pc_write,
    output logic                   out_ifid_write,
    output logic                   out_ifid_flush,
    output logic                   out_idex_flush,
    output logic                   out_pipe_freeze,
    output logic                   out_mem_timeout,
    output logic [STALL_CNT_W-1:0] out_stall_cycles,
    output logic [STALL_CNT_W-1:0] out_flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                freeze;
    logic                load_use;
    logic                branch_flush;
    logic                lu_stall;
    logic [WAIT_W-1:0]   wait_cnt;

    // Load-use match: a load in EX writes a register the ID instruction reads (x0 never matches).
    always_comb begin
        load_use = 1'b0;
        if (in_idex_memread && (in_idex_rd != 5'd0)) begin
            load_use = (in_ifid_rs1_used && (in_idex_rd == in_ifid_rs1)) ||
                       (in_ifid_rs2_used && (in_idex_rd == in_ifid_rs2));
        end
    end

    // Memory-wait state register.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus prioritised hazard outputs: freeze, then branch flush, then load-use.
    always_comb begin
        state_nxt       = state;
        freeze          = 1'b0;
        branch_flush    = 1'b0;
        lu_stall        = 1'b0;
        out_pc_write    = 1'b1;
        out_ifid_write  = 1'b1;
        out_ifid_flush  = 1'b0;
        out_idex_flush  = 1'b0;
        out_pipe_freeze = 1'b0;

        case (state)
            ST_RUN: begin
                if (in_dmem_req && !in_dmem_ready) begin
                    state_nxt = ST_MEM_WAIT;
                    freeze    = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (in_dmem_ready) begin
                    state_nxt = ST_RUN;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        if (!in_rst_n) begin
            // Hold the front end empty and stopped while reset is asserted.
            out_pc_write   = 1'b0;
            out_ifid_write = 1'b0;
            out_ifid_flush = 1'b1;
            out_idex_flush = 1'b1;
        end else if (freeze) begin
            out_pipe_freeze = 1'b1;
            out_pc_write    = 1'b0;
            out_ifid_write  = 1'b0;
        end else if (in_branch_taken) begin
            branch_flush   = 1'b1;
            out_ifid_flush = 1'b1;
            out_idex_flush = 1'b1;
        end else if (load_use) begin
            lu_stall       = 1'b1;
            out_pc_write   = 1'b0;
            out_ifid_write = 1'b0;
            out_idex_flush = 1'b1;
        end
    end

    // Wait-cycle counter and sticky timeout flag; counter saturates at MEM_TIMEOUT.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wait_cnt        <= '0;
            out_mem_timeout <= 1'b0;
        end else if (state == ST_RUN) begin
            if (state_nxt == ST_MEM_WAIT) begin
                wait_cnt <= '0;
            end
        end else if (!in_dmem_ready) begin
            if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                out_mem_timeout <= 1'b1;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_stall_cycles <= '0;
            out_flush_count  <= '0;
        end else begin
            if ((freeze || lu_stall) && (out_stall_cycles != {STALL_CNT_W{1'b1}})) begin
                out_stall_cycles <= out_stall_cycles + STALL_CNT_W'(1);
            end
            if (branch_flush && (out_flush_count != {STALL_CNT_W{1'b1}})) begin
                out_flush_count <= out_flush_count + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed and randomized check of hazard_stall_ctrl against a reference model
module tb_hazard_stall_ctrl;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       idex_memread = 1'b0;
    logic [4:0] idex_rd = '0;
    logic [4:0] ifid_rs1 = '0;
    logic [4:0] ifid_rs2 = '0;
    logic       rs1_used = 1'b0;
    logic       rs2_used = 1'b0;
    logic       branch_taken = 1'b0;
    logic       dmem_req = 1'b0;
    logic       dmem_ready = 1'b0;

    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_flush, a_freeze, a_timeout;
    logic [15:0] a_stall, a_flush;
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_freeze, b_timeout;
    logic [1:0]  b_stall, b_flush;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit m_busy;
    int m_wcnt;
    bit m_to;
    int m_stall, m_flush, m_stall2, m_flush2;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.STALL_CNT_W(16), .MEM_TIMEOUT(TMO)) dut_a (
        .in_clk(clk), .in_rst_n(rst_n), .in_idex_memread(idex_memread), .in_idex_rd(idex_rd),
        .in_ifid_rs1(ifid_rs1), .in_ifid_rs2(ifid_rs2), .in_ifid_rs1_used(rs1_used),
        .in_ifid_rs2_used(rs2_used), .in_branch_taken(branch_taken), .in_dmem_req(dmem_req),
        .in_dmem_ready(dmem_ready), .out_pc_write(a_pc_write), .out_ifid_write(a_ifid_write),
        .out_ifid_flush(a_ifid_flush), .out_idex_flush(a_idex_flush), .out_pipe_freeze(a_freeze),
        .out_mem_timeout(a_timeout), .out_stall_cycles(a_stall), .out_flush_count(a_flush)
    );

    hazard_stall_ctrl #(.STALL_CNT_W(2), .MEM_TIMEOUT(TMO)) dut_b (
        .in_clk(clk), .in_rst_n(rst_n), .in_idex_memread(idex_memread), .in_idex_rd(idex_rd),
        .in_ifid_rs1(ifid_rs1), .in_ifid_rs2(ifid_rs2), .in_ifid_rs1_used(rs1_used),
        .in_ifid_rs2_used(rs2_used), .in_branch_taken(branch_taken), .in_dmem_req(dmem_req),
        .in_dmem_ready(dmem_ready), .out_pc_write(b_pc_write), .out_ifid_write(b_ifid_write),
        .out_ifid_flush(b_ifid_flush), .out_idex_flush(b_idex_flush), .out_pipe_freeze(b_freeze),
        .out_mem_timeout(b_timeout), .out_stall_cycles(b_stall), .out_flush_count(b_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_wcnt = 0; m_to = 0;
        m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
    endtask

    task automatic set_idle();
        idex_memread = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        rs1_used = 0; rs2_used = 0; branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_pc_write", a_pc_write, 0);
        chk("rst_ifid_write", a_ifid_write, 0);
        chk("rst_ifid_flush", a_ifid_flush, 1);
        chk("rst_idex_flush", a_idex_flush, 1);
        chk("rst_freeze", a_freeze, 0);
        chk("rst_timeout", a_timeout, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_flush", a_flush, 0);
        chk("rst_b_stall", b_stall, 0);
    endtask

    // Asserts reset away from the clock edge, checks the held outputs, releases after an edge.
    task automatic do_reset();
        rst_n = 0;
        #1;
        check_reset_values();
        model_clear();
        @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1;
    endtask

    // One clock: compare every output at the negedge, then advance the model on the posedge.
    task automatic cycle();
        bit lu, frz, br, st;
        int lim16 = 65535;
        lu  = idex_memread && (idex_rd != 0) &&
              ((rs1_used && idex_rd == ifid_rs1) || (rs2_used && idex_rd == ifid_rs2));
        frz = (m_busy || dmem_req) && !dmem_ready;
        br  = !frz && branch_taken;
        st  = !frz && !branch_taken && lu;
        @(negedge clk);
        chk("pc_write", a_pc_write, !(frz || st));
        chk("ifid_write", a_ifid_write, !(frz || st));
        chk("ifid_flush", a_ifid_flush, br);
        chk("idex_flush", a_idex_flush, br || st);
        chk("freeze", a_freeze, frz);
        chk("timeout", a_timeout, m_to);
        chk("stall_cycles", a_stall, m_stall);
        chk("flush_count", a_flush, m_flush);
        chk("b_freeze", b_freeze, frz);
        chk("b_stall_cycles", b_stall, m_stall2);
        chk("b_flush_count", b_flush, m_flush2);
        @(posedge clk);
        if (frz || st) begin
            if (m_stall < lim16) m_stall++;
            if (m_stall2 < 3) m_stall2++;
        end
        if (br) begin
            if (m_flush < lim16) m_flush++;
            if (m_flush2 < 3) m_flush2++;
        end
        if (m_busy && !dmem_ready) begin
            m_wcnt++;
            if (m_wcnt >= TMO) m_to = 1;
        end else if (!m_busy && frz) begin
            m_wcnt = 0;
        end
        m_busy = frz;
        #1;
    endtask

    initial begin
        model_clear();
        set_idle();
        #2;
        check_reset_values();
        do_reset();

        // load-use on rs1, then the bubble drains
        idex_memread = 1; idex_rd = 5; ifid_rs1 = 5; rs1_used = 1;
        cycle();
        idex_memread = 0;
        cycle();
        chk("lu_stall_count", a_stall, 1);

        // false dependencies
        set_idle(); idex_memread = 1; idex_rd = 0; ifid_rs1 = 0; rs1_used = 1;
        cycle();
        set_idle(); idex_memread = 1; idex_rd = 7; ifid_rs2 = 7; rs2_used = 0;
        cycle();
        chk("false_dep_count", a_stall, 1);

        // branch beats load-use
        do_reset();
        idex_memread = 1; idex_rd = 9; ifid_rs2 = 9; rs2_used = 1; branch_taken = 1;
        cycle();
        set_idle();
        cycle();
        chk("br_flush_count", a_flush, 1);
        chk("br_stall_count", a_stall, 0);

        // memory wait with a held taken branch
        do_reset();
        dmem_req = 1; branch_taken = 1;
        repeat (3) cycle();
        dmem_ready = 1;
        cycle();
        set_idle();
        cycle();
        chk("mw_stall_count", a_stall, 3);
        chk("mw_flush_count", a_flush, 1);

        // timeout: six unready cycles, flag stays after ready
        do_reset();
        dmem_req = 1;
        repeat (6) cycle();
        chk("tmo_set", a_timeout, 1);
        dmem_req = 0; dmem_ready = 1;
        cycle();
        dmem_ready = 0;
        cycle();
        chk("tmo_sticky", a_timeout, 1);

        // reset in the middle of a wait, then no freeze after release
        dmem_req = 1;
        cycle();
        cycle();
        dmem_req = 0;
        do_reset();
        repeat (2) cycle();

        // saturation on the 2-bit instance
        idex_memread = 1; idex_rd = 3; ifid_rs1 = 3; rs1_used = 1;
        repeat (5) cycle();
        set_idle();
        cycle();
        chk("sat_b_stall", b_stall, 3);
        chk("sat_a_stall", a_stall, 5);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            idex_memread = 1'($urandom_range(0, 1));
            idex_rd      = 5'($urandom_range(0, 3));
            ifid_rs1     = 5'($urandom_range(0, 3));
            ifid_rs2     = 5'($urandom_range(0, 3));
            rs1_used     = 1'($urandom_range(0, 1));
            rs2_used     = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 5) == 0);
            dmem_req     = ($urandom_range(0, 3) == 0);
            dmem_ready   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the five-stage RISC-V core. It complements the EX-stage forwarding unit by handling the hazards that forwarding cannot resolve:
- load-use dependencies, by stalling IF/ID and inserting an ID/EX bubble;
- taken branches and jumps, by flushing the wrong-path stages;
- slow data-memory accesses, by freezing the whole pipeline until the memory answers.

It also keeps a memory-wait state machine, a sticky timeout flag, and saturating stall and flush statistics counters.

## Interface
- STALL_CNT_W, 16, width of the statistics counters.
- MEM_TIMEOUT, 255, number of MEM_WAIT cycles after which the timeout flag sets (must be ≥1).

- in_clk  input  1  core clock; all state updates on the rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_idex_memread  input  1  instruction in ID/EX is a load.
- in_idex_rd  input  5  destination register of the ID/EX instruction.
- in_ifid_rs1  input  5  rs1 of the IF/ID instruction.
- in_ifid_rs2  input  5  rs2 of the IF/ID instruction.
- in_ifid_rs1_used  input  1  IF/ID instruction reads rs1.
- in_ifid_rs2_used  input  1  IF/ID instruction reads rs2.
- in_branch_taken  input  1  branch or jump resolved taken in EX this cycle.
- in_dmem_req  input  1  EX/MEM instruction issues a data-memory access this cycle.
- in_dmem_ready  input  1  data memory completes the access this cycle.
- out_pc_write  output  1  PC register update enable.
- out_ifid_write  output  1  IF/ID register update enable.
- out_ifid_flush  output  1  load a NOP into IF/ID.
- out_idex_flush  output  1  load a bubble (all controls 0) into ID/EX.
- out_pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
- out_mem_timeout  output  1  sticky flag: a memory wait exceeded MEM_TIMEOUT.
- out_stall_cycles  output  STALL_CNT_W  saturating count of stall cycles.
- out_flush_count  output  STALL_CNT_W  saturating count of branch-flush cycles.

## Operation

State machine has two states, RUN and MEM_WAIT.
- RUN → MEM_WAIT when in_dmem_req=1 and in_dmem_ready=0.
- MEM_WAIT → RUN when in_dmem_ready=1.

freeze = (RUN and in_dmem_req and !in_dmem_ready) or (MEM_WAIT and !in_dmem_ready).

Output priority, highest first; each is evaluated combinationally every cycle:
1. **Freeze.** out_pipe_freeze=1, out_pc_write=0, out_ifid_write=0, both flushes 0. Branch and load-use logic are ignored. A held taken branch is still asserted when the freeze releases, so it is acted on then.
2. **Branch flush** (in_branch_taken, not frozen). out_ifid_flush=1, out_idex_flush=1, out_pc_write=1 so the PC loads the target, out_ifid_write=1. Load-use detection is suppressed because the ID instruction is on the wrong path.
3. **Load-use stall.** Condition: in_idex_memread and in_idex_rd≠0 and ((in_ifid_rs1_used and in_idex_rd==in_ifid_rs1) or (in_ifid_rs2_used and in_idex_rd==in_ifid_rs2)).
   - Response: out_pc_write=0, out_ifid_write=0, out_idex_flush=1, out_ifid_flush=0.
4. **Default.** out_pc_write=1, out_ifid_write=1, all flushes and freeze 0.

Timeout:
- A wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle with in_dmem_ready=0.
- When it reaches MEM_TIMEOUT, out_mem_timeout sets. The flag is cleared only by reset.
- The FSM stays in MEM_WAIT and keeps freezing until ready.

Counters:
- out_stall_cycles increments on every cycle with freeze or load-use stall active.
- out_flush_count increments on every branch-flush cycle.
- Both saturate at all-ones and never wrap.

## Timing
- Hazard outputs are combinational from the current inputs and state, so they take effect at the same edge.
- Load-use costs exactly one bubble: after the stall edge, ID/EX holds the bubble, in_idex_memread falls, and the stall deasserts.
- A memory access with ready in the request cycle costs 0 freeze cycles. An access with ready N cycles later freezes for N cycles; the ready cycle itself is unfrozen.
- in_dmem_ready arriving while in RUN without in_dmem_req is ignored.
- Asynchronous reset:
  - State, registers and outputs: FSM→RUN, wait counter=0, out_mem_timeout=0, both statistics counters=0.
  - Held control outputs while in_rst_n=0: out_pc_write=0, out_ifid_write=0, out_ifid_flush=1, out_idex_flush=1, out_pipe_freeze=0.
- Reset asserted mid-MEM_WAIT abandons the wait immediately, with no freeze after release.
- Counters register on the edge after the event.

## Test plan
- Load-use dependency:
  - Stimulus: idex_memread=1, idex_rd=5, ifid_rs1=5, rs1_used=1.
  - Response: one cycle of pc_write=0, ifid_write=0, idex_flush=1. Next cycle, with memread=0, all defaults. stall_cycles=1.
- False dependencies:
  - rd=0 with rs1=0 → no stall.
  - rd=7, rs2=7 but rs2_used=0 → no stall.
- Branch versus load-use:
  - Stimulus: branch_taken=1 together with a load-use match.
  - Response: ifid_flush=1, idex_flush=1, pc_write=1, no stall. flush_count=1, stall_cycles=0.
- Memory wait:
  - Stimulus: dmem_req=1, ready low for 3 cycles then high, with branch_taken=1 throughout.
  - Response: freeze=1 with no flushes for 3 cycles. The FSM returns to RUN on the ready cycle, where the flush asserts. stall_cycles=3.
- Timeout with MEM_TIMEOUT=4:
  - Stimulus: ready held low for 6 cycles.
  - Response: out_mem_timeout rises after the 4th wait cycle and stays high after ready.
  - Then assert in_rst_n=0 mid-wait: all registers clear asynchronously and the reset output values appear immediately.
- Saturation with STALL_CNT_W=2: 5 stall cycles → out_stall_cycles=3, no wrap.
